// File: rtl/line_burst_adapter.sv
// Bridges a 256-bit cache line interface onto a BEAT_W-wide memory burst bus.
// Writeback wins over fill when both are requested; BEAT_W*NUM_BEATS must be 256.
module line_burst_adapter #(
  parameter int BEAT_W    = 64,
  parameter int NUM_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_addr,
  input  logic [255:0]      line_wdata,
  output logic [255:0]      line_rdata,
  input  logic              line_read,
  input  logic              line_write,
  output logic              line_resp,
  output logic [31:0]       burst_addr,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  output logic              burst_read,
  output logic              burst_write,
  input  logic              burst_resp
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      addr_q;
  logic [255:0]     wdata_q;
  logic [255:0]     rdata_q;

  assign cnt_next = (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (line_write)     state_next = WRITE;
        else if (line_read) state_next = READ;
      end
      READ, WRITE: begin
        if (burst_resp && (cnt == LAST_BEAT)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address is stored already line-aligned so the burst side just gates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write) begin
            addr_q  <= line_addr & LINE_MASK;
            wdata_q <= line_wdata;
            cnt     <= '0;
          end else if (line_read) begin
            addr_q <= line_addr & LINE_MASK;
            cnt    <= '0;
          end
        end
        READ: begin
          if (burst_resp) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
              if (cnt == CNT_W'(k)) rdata_q[k*BEAT_W +: BEAT_W] <= burst_rdata;
            end
            cnt <= cnt_next;
          end
        end
        WRITE: begin
          if (burst_resp) cnt <= cnt_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    burst_wdata = '0;
    if (state == WRITE) begin
      for (int k = 0; k < NUM_BEATS; k++) begin
        if (cnt == CNT_W'(k)) burst_wdata = wdata_q[k*BEAT_W +: BEAT_W];
      end
    end
  end

  assign burst_read  = (state == READ);
  assign burst_write = (state == WRITE);
  assign burst_addr  = (state == READ || state == WRITE) ? addr_q : '0;
  assign line_resp   = (state == DONE);
  assign line_rdata  = rdata_q;

endmodule
